mem_access_stage: RTL and testbench

- Data-memory access stage between EX_MEM and MEM_WB.
- Takes the load/store request held in EX_MEM and runs it on a variable-latency data-memory bus with a req/ack handshake.
- Produces MEM_read_data_mem for MEM_WB.
- Raises mem_stall to freeze PC, IF_ID, ID_EX and EX_MEM while an access is outstanding.

---
 rtl/mem_access_stage.sv | 114 +++++++++++
 tb/tb_mem_access_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Data-memory access stage: runs the EX_MEM load/store on a req/ack bus,
// freezes the front of the pipe while the access is outstanding.
module mem_access_stage #(
   parameter int unsigned TIMEOUT  = 16,
   parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MEM_MemRead,
   input  logic        MEM_MemWrite,
   input  logic [31:0] MEM_alu_result,
   input  logic [31:0] MEM_write_data,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] MEM_read_data_mem,
   output logic        mem_stall,
   output logic        mem_err
);

   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               req_nxt, we_nxt, err_nxt;
   logic [31:0]        addr_nxt, wdata_nxt, rdata_nxt;
   logic               access, misaligned, timed_out;

   assign access     = MEM_MemRead | MEM_MemWrite;
   assign misaligned = access & (MEM_alu_result[1:0] != 2'b00);
   assign timed_out  = (cnt == CNT_W'(TIMEOUT - 1));

   // State and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state             <= IDLE;
         cnt               <= '0;
         dmem_req          <= 1'b0;
         dmem_we           <= 1'b0;
         dmem_addr         <= '0;
         dmem_wdata        <= '0;
         MEM_read_data_mem <= '0;
         mem_err           <= 1'b0;
      end else begin
         state             <= state_nxt;
         cnt               <= cnt_nxt;
         dmem_req          <= req_nxt;
         dmem_we           <= we_nxt;
         dmem_addr         <= addr_nxt;
         dmem_wdata        <= wdata_nxt;
         MEM_read_data_mem <= rdata_nxt;
         mem_err           <= err_nxt;
      end
   end

   // Next state; DONE always returns to IDLE so accesses never overlap
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (access && !misaligned) state_nxt = BUSY;
         BUSY:    if (dmem_ack || timed_out) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values of registered outputs and the combinational stall
   always_comb begin
      req_nxt   = dmem_req;
      we_nxt    = dmem_we;
      addr_nxt  = dmem_addr;
      wdata_nxt = dmem_wdata;
      rdata_nxt = MEM_read_data_mem;
      err_nxt   = mem_err;
      cnt_nxt   = cnt;
      mem_stall = 1'b0;
      case (state)
         IDLE: begin
            if (access) begin
               if (misaligned) begin
                  err_nxt = 1'b1;
                  if (!MEM_MemWrite) rdata_nxt = ERR_DATA;
               end else begin
                  mem_stall = rst;
                  req_nxt   = 1'b1;
                  we_nxt    = MEM_MemWrite;
                  addr_nxt  = MEM_alu_result;
                  wdata_nxt = MEM_write_data;
                  cnt_nxt   = '0;
               end
            end
         end
         BUSY: begin
            mem_stall = rst;
            cnt_nxt   = cnt + CNT_W'(1);
            if (dmem_ack) begin
               req_nxt = 1'b0;
               if (!dmem_we) rdata_nxt = dmem_rdata;
            end else if (timed_out) begin
               req_nxt = 1'b0;
               err_nxt = 1'b1;
               if (!dmem_we) rdata_nxt = ERR_DATA;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: vector table driven through a bus responder,
// expected load results checked through a scoreboard queue.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        MEM_MemRead, MEM_MemWrite;
   logic [31:0] MEM_alu_result, MEM_write_data;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [31:0] MEM_read_data_mem;
   logic        mem_stall, mem_err;

   int unsigned n_pass = 0;
   int unsigned n_total = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int unsigned ack_at;    // BUSY cycle (1-based) in which ack is given; 0 = never
      logic [31:0] rdata;
      int unsigned exp_stall;
      int unsigned exp_req;
      logic        exp_we;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t vecs[10];

   mem_access_stage #(.TIMEOUT(16), .ERR_DATA(32'hDEAD_BEEF)) dut (
      .clk(clk), .rst(rst),
      .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
      .MEM_alu_result(MEM_alu_result), .MEM_write_data(MEM_write_data),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .MEM_read_data_mem(MEM_read_data_mem), .mem_stall(mem_stall), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else n_pass++;
   endtask

   task automatic pop_check(input string name, input logic [31:0] act);
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
      end else begin
         e = exp_q.pop_front();
         check(name, act, e);
      end
   endtask

   task automatic clear_inputs();
      MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0;
      MEM_alu_result = '0; MEM_write_data = '0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Entered and left one time unit after a rising edge
   task automatic run_vec(input int idx, input vec_t v);
      int unsigned stall_cnt = 0;
      int unsigned req_cnt = 0;
      int unsigned cyc = 0;
      bit done = 1'b0;
      bit mis;
      logic [1:0] lo;
      lo  = v.addr[1:0];
      mis = (lo != 2'b00);
      MEM_MemRead = v.rd; MEM_MemWrite = v.wr;
      MEM_alu_result = v.addr; MEM_write_data = v.wdata;
      exp_q.push_back(v.exp_rd);
      while (!done && cyc < 64) begin
         @(negedge clk);
         if (mem_stall) stall_cnt++;
         if (dmem_req) begin
            req_cnt++;
            check($sformatf("v%0d_we", idx), 32'(dmem_we), 32'(v.exp_we));
            check($sformatf("v%0d_addr", idx), dmem_addr, v.addr);
            check($sformatf("v%0d_wdata", idx), dmem_wdata, v.wdata);
            if (req_cnt == v.ack_at) begin
               dmem_ack = 1'b1; dmem_rdata = v.rdata;
            end
         end
         if (!mem_stall) begin
            done = 1'b1;
            if (!mis) begin
               pop_check($sformatf("v%0d_rdata", idx), MEM_read_data_mem);
               check($sformatf("v%0d_err", idx), 32'(mem_err), 32'(v.exp_err));
            end
         end
         step();
         dmem_ack = 1'b0; dmem_rdata = '0;
         cyc++;
      end
      if (!done) check($sformatf("v%0d_finished", idx), 32'd0, 32'd1);
      clear_inputs();
      if (mis) begin
         pop_check($sformatf("v%0d_rdata", idx), MEM_read_data_mem);
         check($sformatf("v%0d_err", idx), 32'(mem_err), 32'(v.exp_err));
         check($sformatf("v%0d_noreq", idx), 32'(dmem_req), 32'd0);
      end
      check($sformatf("v%0d_stall_cycles", idx), stall_cnt, v.exp_stall);
      check($sformatf("v%0d_req_cycles", idx), req_cnt, v.exp_req);
   endtask

   initial begin
      //            rd    wr    addr          wdata         ack rdata         stall req we    exp_rd        err
      vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,        1,  32'h1234_5678, 2,  1,  1'b0, 32'h1234_5678, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 32'h0000_0200, 32'hCAFE_F00D, 4,  32'h5555_5555, 5,  4,  1'b1, 32'h1234_5678, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0,        3,  32'h0BAD_F00D, 4,  3,  1'b0, 32'h0BAD_F00D, 1'b0};
      vecs[3] = '{1'b1, 1'b1, 32'h0000_0040, 32'h1111_2222, 2,  32'h7777_7777, 3,  2,  1'b1, 32'h0BAD_F00D, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 32'h0000_0400, 32'h0,        16, 32'h0000_AC16, 17, 16, 1'b0, 32'h0000_AC16, 1'b0};
      vecs[5] = '{1'b1, 1'b0, 32'h0000_0500, 32'h0,        0,  32'hA5A5_A5A5, 17, 16, 1'b0, 32'hDEAD_BEEF, 1'b1};
      vecs[6] = '{1'b1, 1'b0, 32'h0000_0600, 32'h0,        1,  32'h600D_600D, 2,  1,  1'b0, 32'h600D_600D, 1'b1};
      vecs[7] = '{1'b1, 1'b0, 32'h0000_0102, 32'h0,        0,  32'h0,         0,  0,  1'b0, 32'hDEAD_BEEF, 1'b1};
      vecs[8] = '{1'b0, 1'b1, 32'h0000_0203, 32'h1234_0000, 0,  32'h0,         0,  0,  1'b0, 32'hDEAD_BEEF, 1'b1};
      vecs[9] = '{1'b0, 1'b1, 32'h0000_07FC, 32'h0,        2,  32'h3141_5926, 3,  2,  1'b1, 32'hDEAD_BEEF, 1'b1};

      // Reset with a pending load: stall must stay low
      rst = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
      clear_inputs();
      MEM_MemRead = 1'b1; MEM_alu_result = 32'h100;
      #12;
      check("rst_stall", 32'(mem_stall), 32'd0);
      check("rst_req", 32'(dmem_req), 32'd0);
      check("rst_addr", dmem_addr, 32'd0);
      check("rst_rdata", MEM_read_data_mem, 32'd0);
      check("rst_err", 32'(mem_err), 32'd0);
      clear_inputs();
      step();
      rst = 1'b1;
      step();

      // Stray ack in IDLE
      @(negedge clk);
      dmem_ack = 1'b1; dmem_rdata = 32'h9999_9999;
      step();
      dmem_ack = 1'b0; dmem_rdata = '0;
      @(negedge clk);
      check("stray_idle_rdata", MEM_read_data_mem, 32'd0);
      check("stray_idle_req", 32'(dmem_req), 32'd0);
      step();

      foreach (vecs[i]) run_vec(i, vecs[i]);

      // Back-to-back loads with a stray ack during DONE
      MEM_MemRead = 1'b1; MEM_alu_result = 32'h10;
      exp_q.push_back(32'hA);
      @(negedge clk);
      check("b2b_idle0_stall", 32'(mem_stall), 32'd1);
      step();
      @(negedge clk);
      check("b2b_busy0_req", 32'(dmem_req), 32'd1);
      check("b2b_busy0_addr", dmem_addr, 32'h10);
      dmem_ack = 1'b1; dmem_rdata = 32'hA;
      step();
      dmem_ack = 1'b0;
      @(negedge clk);
      check("b2b_done0_stall", 32'(mem_stall), 32'd0);
      pop_check("b2b_done0_rdata", MEM_read_data_mem);
      dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
      step();
      dmem_ack = 1'b0; dmem_rdata = '0;
      MEM_alu_result = 32'h14;
      exp_q.push_back(32'hB);
      @(negedge clk);
      check("b2b_idle1_req", 32'(dmem_req), 32'd0);
      check("b2b_idle1_stall", 32'(mem_stall), 32'd1);
      check("b2b_idle1_rdata", MEM_read_data_mem, 32'hA);
      step();
      @(negedge clk);
      check("b2b_busy1_req", 32'(dmem_req), 32'd1);
      check("b2b_busy1_addr", dmem_addr, 32'h14);
      dmem_ack = 1'b1; dmem_rdata = 32'hB;
      step();
      dmem_ack = 1'b0; dmem_rdata = '0;
      @(negedge clk);
      check("b2b_done1_stall", 32'(mem_stall), 32'd0);
      pop_check("b2b_done1_rdata", MEM_read_data_mem);
      step();
      clear_inputs();

      // Asynchronous reset in the middle of BUSY
      MEM_MemRead = 1'b1; MEM_alu_result = 32'h800;
      @(negedge clk);
      step();
      @(negedge clk);
      check("arst_busy_req", 32'(dmem_req), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("arst_req", 32'(dmem_req), 32'd0);
      check("arst_stall", 32'(mem_stall), 32'd0);
      check("arst_we", 32'(dmem_we), 32'd0);
      check("arst_addr", dmem_addr, 32'd0);
      check("arst_rdata", MEM_read_data_mem, 32'd0);
      check("arst_err", 32'(mem_err), 32'd0);
      clear_inputs();
      step();
      @(negedge clk);
      check("arst_hold_req", 32'(dmem_req), 32'd0);
      #2 rst = 1'b1;
      step();
      run_vec(10, '{1'b1, 1'b0, 32'h0000_0900, 32'h0, 1, 32'h1357_9BDF, 2, 1, 1'b0, 32'h1357_9BDF, 1'b0});

      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
